// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 register index constants and types
package y86_pkg;
  typedef logic [3:0] reg_idx_t;
  localparam reg_idx_t RNONE = 4'hF;
  localparam reg_idx_t R_RAX = 4'd0;
  localparam reg_idx_t R_RCX = 4'd1;
  localparam reg_idx_t R_RDX = 4'd2;
  localparam reg_idx_t R_RBX = 4'd3;
  localparam reg_idx_t R_RSP = 4'd4;
  localparam reg_idx_t R_RBP = 4'd5;
  localparam reg_idx_t R_RSI = 4'd6;
  localparam reg_idx_t R_RDI = 4'd7;
  localparam reg_idx_t R_R8  = 4'd8;
  localparam reg_idx_t R_R9  = 4'd9;
  localparam reg_idx_t R_R10 = 4'd10;
  localparam reg_idx_t R_R11 = 4'd11;
  localparam reg_idx_t R_R12 = 4'd12;
  localparam reg_idx_t R_R13 = 4'd13;
  localparam reg_idx_t R_R14 = 4'd14;
endpackage

// File: rtl/y86_rf_rdport.sv
// y86_rf_rdport: combinational register read with optional M-over-E write bypass
module y86_rf_rdport
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  reg_idx_t            addr,
  input  logic [DATA_W-1:0]   regs [NREG],
  input  logic                byp_en,
  input  reg_idx_t            dstE,
  input  reg_idx_t            dstM,
  input  logic [DATA_W-1:0]   valE,
  input  logic [DATA_W-1:0]   valM,
  output logic [DATA_W-1:0]   val
);
  logic [DATA_W-1:0] stored;
  always_comb begin
    stored = '0;
    for (int i = 0; i < NREG; i++) if (addr == 4'(i)) stored = regs[i];
  end
  assign val = addr >= 4'(NREG)            ? '0   :
               byp_en && addr == dstM      ? valM :
               byp_en && addr == dstE      ? valE : stored;
endmodule

// File: rtl/y86_regfile.sv
// y86_regfile: Y86-64 register file, two read ports, E/M write ports, bypass, sticky illegal-dst flag
module y86_regfile
  import y86_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter int                NREG       = 15,
  parameter bit                BYPASS     = 1,
  parameter bit                INIT_INDEX = 1,
  parameter logic [DATA_W-1:0] SP_INIT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  input  logic [3:0]        dstE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val,
  output logic              err
);
  logic [DATA_W-1:0] regs [NREG];
  logic byp_en, ill;
  assign byp_en = BYPASS && wr_en;
  assign ill = wr_en && ((dstE != RNONE && dstE >= 4'(NREG)) || (dstM != RNONE && dstM >= 4'(NREG)));
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    localparam logic [DATA_W-1:0] RV = g == int'(R_RSP) ? SP_INIT : INIT_INDEX ? DATA_W'(g) : '0;
    always_ff @(posedge clk or posedge rst)
      if (rst) regs[g] <= RV;
      else if (wr_en && dstM == 4'(g)) regs[g] <= valM;
      else if (wr_en && dstE == 4'(g)) regs[g] <= valE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if (ill) err <= 1'b1;
  y86_rf_rdport #(.DATA_W(DATA_W), .NREG(NREG)) u_rd_a (
    .addr(srcA), .regs(regs), .byp_en(byp_en), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .val(valA));
  y86_rf_rdport #(.DATA_W(DATA_W), .NREG(NREG)) u_rd_b (
    .addr(srcB), .regs(regs), .byp_en(byp_en), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .val(valB));
  y86_rf_rdport #(.DATA_W(DATA_W), .NREG(NREG)) u_rd_dbg (
    .addr(dbg_sel), .regs(regs), .byp_en(1'b0), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .val(dbg_val));
endmodule

// File: tb/tb_y86_regfile.sv
// tb_y86_regfile: directed checks of reset, writes, bypass, stall, illegal dst and async reset
module tb_y86_regfile;
  logic clk = 0, rst = 0, wr_en = 0;
  logic [3:0] srcA = 4'hF, srcB = 4'hF, dstE = 4'hF, dstM = 4'hF, dbg_sel = 0;
  logic [63:0] valE = 0, valM = 0;
  logic [63:0] a_def, b_def, d_def, a_nb, b_nb, d_nb, a_n8, b_n8, d_n8;
  logic e_def, e_nb, e_n8;
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  y86_regfile u_def (.clk(clk), .rst(rst), .wr_en(wr_en), .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .valA(a_def), .valB(b_def), .dbg_sel(dbg_sel), .dbg_val(d_def), .err(e_def));
  y86_regfile #(.BYPASS(0)) u_nb (.clk(clk), .rst(rst), .wr_en(wr_en), .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .valA(a_nb), .valB(b_nb), .dbg_sel(dbg_sel), .dbg_val(d_nb), .err(e_nb));
  y86_regfile #(.NREG(8)) u_n8 (.clk(clk), .rst(rst), .wr_en(wr_en), .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .valA(a_n8), .valB(b_n8), .dbg_sel(dbg_sel), .dbg_val(d_n8), .err(e_n8));
  task automatic do_reset;
    @(negedge clk);
    wr_en = 0; dstE = 4'hF; dstM = 4'hF; srcA = 4'hF; srcB = 4'hF;
    rst = 1; #1 rst = 0;
  endtask
  task automatic test_reset;
    logic [63:0] exp_def, exp_n8;
    do_reset();
    for (int s = 0; s < 16; s++) begin
      dbg_sel = 4'(s); #1;
      exp_def = s == 15 ? 64'd0 : 64'(s);
      exp_n8 = s >= 8 ? 64'd0 : 64'(s);
      vectors++; if (d_def !== exp_def) begin errors++; $display("FAIL reset_dbg_def[%0d] got %h exp %h", s, d_def, exp_def); end
      vectors++; if (d_n8 !== exp_n8) begin errors++; $display("FAIL reset_dbg_n8[%0d] got %h exp %h", s, d_n8, exp_n8); end
    end
    vectors++; if (e_def !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", e_def); end
  endtask
  task automatic test_dual_write;
    do_reset();
    @(negedge clk); wr_en = 1; dstE = 2; valE = 64'hAA; dstM = 3; valM = 64'hBB;
    @(negedge clk); wr_en = 0; dstE = 4'hF; dstM = 4'hF;
    dbg_sel = 2; #1;
    vectors++; if (d_def !== 64'hAA) begin errors++; $display("FAIL dual_reg2 got %h exp aa", d_def); end
    dbg_sel = 3; #1;
    vectors++; if (d_def !== 64'hBB) begin errors++; $display("FAIL dual_reg3 got %h exp bb", d_def); end
    @(negedge clk); wr_en = 1; dstE = 4; valE = 64'h10; dstM = 4; valM = 64'h20;
    @(negedge clk); wr_en = 0; dstE = 4'hF; dstM = 4'hF;
    dbg_sel = 4; #1;
    vectors++; if (d_def !== 64'h20) begin errors++; $display("FAIL collide_reg4 got %h exp 20", d_def); end
  endtask
  task automatic test_bypass;
    do_reset();
    @(negedge clk); srcA = 5; wr_en = 1; dstE = 5; valE = 64'h1234; #1;
    vectors++; if (a_def !== 64'h1234) begin errors++; $display("FAIL byp_e got %h exp 1234", a_def); end
    vectors++; if (a_nb !== 64'd5) begin errors++; $display("FAIL nobyp_e got %h exp 5", a_nb); end
    dstM = 5; valM = 64'h55; #1;
    vectors++; if (a_def !== 64'h55) begin errors++; $display("FAIL byp_m got %h exp 55", a_def); end
    vectors++; if (a_nb !== 64'd5) begin errors++; $display("FAIL nobyp_m got %h exp 5", a_nb); end
    dbg_sel = 5; #1;
    vectors++; if (d_def !== 64'd5) begin errors++; $display("FAIL dbg_nobyp got %h exp 5", d_def); end
    @(negedge clk); wr_en = 0; dstE = 4'hF; dstM = 4'hF; #1;
    vectors++; if (a_nb !== 64'h55) begin errors++; $display("FAIL nobyp_after got %h exp 55", a_nb); end
    vectors++; if (a_def !== 64'h55) begin errors++; $display("FAIL byp_after got %h exp 55", a_def); end
    srcB = 4'hF; wr_en = 1; valE = 64'h99; valM = 64'h98; #1;
    vectors++; if (b_def !== 64'd0) begin errors++; $display("FAIL rnone_nomatch got %h exp 0", b_def); end
    srcB = 6; dstE = 6; valE = 64'hC6; #1;
    vectors++; if (b_def !== 64'hC6) begin errors++; $display("FAIL byp_portb got %h exp c6", b_def); end
    wr_en = 0; dstE = 4'hF;
  endtask
  task automatic test_stall;
    do_reset();
    @(negedge clk); wr_en = 0; dstE = 1; valE = 64'hFF; srcA = 1; dbg_sel = 1; #1;
    vectors++; if (a_def !== 64'd1) begin errors++; $display("FAIL stall_nobyp got %h exp 1", a_def); end
    @(negedge clk); #1;
    vectors++; if (d_def !== 64'd1) begin errors++; $display("FAIL stall_reg1 got %h exp 1", d_def); end
    vectors++; if (e_def !== 1'b0) begin errors++; $display("FAIL stall_err got %b exp 0", e_def); end
    dstE = 4'hF;
  endtask
  task automatic test_illegal;
    do_reset();
    @(negedge clk); wr_en = 0; dstE = 10; valE = 64'hE1;
    @(negedge clk); #1;
    vectors++; if (e_n8 !== 1'b0) begin errors++; $display("FAIL ill_stalled_err got %b exp 0", e_n8); end
    wr_en = 1; dstM = 2; valM = 64'h77; srcA = 10; #1;
    vectors++; if (a_n8 !== 64'd0) begin errors++; $display("FAIL ill_read got %h exp 0", a_n8); end
    @(negedge clk); wr_en = 0; dstE = 4'hF; dstM = 4'hF; dbg_sel = 2; #1;
    vectors++; if (e_n8 !== 1'b1) begin errors++; $display("FAIL ill_err got %b exp 1", e_n8); end
    vectors++; if (d_n8 !== 64'h77) begin errors++; $display("FAIL ill_legal_m got %h exp 77", d_n8); end
    vectors++; if (e_def !== 1'b0) begin errors++; $display("FAIL legal15_err got %b exp 0", e_def); end
    dbg_sel = 10; #1;
    vectors++; if (d_def !== 64'hE1) begin errors++; $display("FAIL legal15_reg10 got %h exp e1", d_def); end
    repeat (3) @(negedge clk); #1;
    vectors++; if (e_n8 !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b exp 1", e_n8); end
  endtask
  task automatic test_async_reset;
    @(negedge clk); dbg_sel = 2; #2 rst = 1; #1;
    vectors++; if (d_n8 !== 64'd2) begin errors++; $display("FAIL arst_reg2 got %h exp 2", d_n8); end
    vectors++; if (e_n8 !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", e_n8); end
    wr_en = 1; dstE = 2; valE = 64'hEE; srcA = 2; #1;
    vectors++; if (a_def !== 64'hEE) begin errors++; $display("FAIL arst_byp got %h exp ee", a_def); end
    @(negedge clk); wr_en = 0; dstE = 4'hF; rst = 0; #1;
    vectors++; if (d_def !== 64'd2) begin errors++; $display("FAIL arst_lost got %h exp 2", d_def); end
    @(negedge clk); wr_en = 1; dstE = 2; valE = 64'hEF;
    @(negedge clk); wr_en = 0; dstE = 4'hF; #1;
    vectors++; if (d_def !== 64'hEF) begin errors++; $display("FAIL post_rst_write got %h exp ef", d_def); end
  endtask
  initial begin
    rst = 1; #1 rst = 0;
    test_reset();
    test_dual_write();
    test_bypass();
    test_stall();
    test_illegal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
